scmp_dly_engine: RTL

//  Multi-cycle engine for the SC/MP DLY instruction. Sits beside scmp_alu under the

---
 rtl/scmp_dly_engine.sv | 94 +++++++++
 1 files changed

// File: rtl/scmp_dly_engine.sv
// SC/MP DLY instruction engine: loads the architected microcycle delay, counts it
// down through a clocks-per-microcycle prescaler, then returns AC=0xFF with a done pulse.
module scmp_dly_engine #(
  parameter int CLKS_PER_UCYC = 4,
  parameter int CNT_W         = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] ac_i,
  input  logic [7:0] disp_i,
  input  logic       stall,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic [7:0] ac_o,
  output logic       ac_we
);

  localparam int PRE_W = (CLKS_PER_UCYC > 1) ? $clog2(CLKS_PER_UCYC) : 1;
  localparam logic [PRE_W-1:0] PRE_RLD = PRE_W'(CLKS_PER_UCYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [PRE_W-1:0] pre, pre_nxt;

  // 13 + 2*ac + 514*disp, built from shifts so the full 131593 maximum fits in CNT_W.
  function automatic logic [CNT_W-1:0] dly_count(input logic [7:0] ac, input logic [7:0] disp);
    logic [CNT_W-1:0] a;
    logic [CNT_W-1:0] d;
    a = CNT_W'(ac);
    d = CNT_W'(disp);
    return CNT_W'(13) + (a << 1) + (d << 9) + (d << 1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      pre   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pre   <= pre_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pre_nxt   = pre;
    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      pre_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt_nxt   = dly_count(ac_i, disp_i);
            pre_nxt   = PRE_RLD;
            state_nxt = COUNT;
          end
        end
        COUNT: begin
          // A stalled bus freezes the whole count, prescaler included.
          if (!stall) begin
            if (pre == '0) begin
              pre_nxt = PRE_RLD;
              cnt_nxt = cnt - CNT_W'(1);
              if (cnt == CNT_W'(1)) state_nxt = DONE;
            end else begin
              pre_nxt = pre - PRE_W'(1);
            end
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign ac_o  = {8{done}};
  assign ac_we = done;

endmodule
